nw_traceback: RTL and testbench
===============================

Name: nw_traceback

Overview:
- Traceback engine for the Needleman-Wunsch array; the reading side of the direction-symbol matrix written by the per-cell max/score units.
- On start, walks from cell (len_a, len_b) back to (0,0), reading one 3-bit direction symbol per interior cell from a synchronous-read symbol memory.
- Emits one alignment step per valid/ready handshake to the downstream alignment formatter.

Parameters:
- LEN_A, 128, maximum length of sequence A (rows 1..LEN_A).
- LEN_B, 128, maximum length of sequence B (columns 1..LEN_B).
- IDX_W, 8, width of row/column indices; must hold 0..max(LEN_A, LEN_B).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request traceback; accepted only in IDLE.
- len_a  in  IDX_W  actual length of A; sampled on accepted start.
- len_b  in  IDX_W  actual length of B; sampled on accepted start.
- rd_en  out  1  symbol memory read strobe.
- rd_row  out  IDX_W  read row address.
- rd_col  out  IDX_W  read column address.
- rd_symbol  in  3  symbol returned one cycle after rd_en: 3'b100 left, 3'b010 up, 3'b001 diag.
- out_valid  out  1  step available.
- out_ready  in  1  downstream accepts step.
- out_dir  out  3  step direction, same one-hot encoding as rd_symbol.
- out_row  out  IDX_W  row of the cell the step leaves.
- out_col  out  IDX_W  column of the cell the step leaves.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when traceback ends.
- error  out  1  sticky fault flag; cleared on next accepted start.
- path_len  out  IDX_W+1  steps emitted (see Optional Feature).

Behaviour:
- Reset (async): state IDLE; every output 0; cur_row/cur_col 0.
- States: IDLE, READ, CAPT, EMIT, DONE.
- IDLE, start=1:
  - Latch cur_row=len_a, cur_col=len_b, clear error.
  - If len_a>LEN_A or len_b>LEN_B: error=1, go to DONE.
  - Else if both lengths are 0: go to DONE.
  - Else if both lengths are nonzero: go to READ.
  - Else (one length is 0): go to EMIT with a forced direction.
- start while busy: ignored.
- READ (1 cycle): rd_en=1, rd_row=cur_row, rd_col=cur_col; go to CAPT.
- CAPT (1 cycle): sample rd_symbol.
  - Not exactly one-hot: error=1, go to DONE; no step is emitted.
  - Otherwise latch it as dir and go to EMIT.
- Forced directions (no memory read):
  - cur_row==0, cur_col>0: dir=left.
  - cur_col==0, cur_row>0: dir=up.
- EMIT: out_valid=1 with out_dir=dir, out_row=cur_row, out_col=cur_col.
  - Fields must stay stable while out_ready=0.
  - On out_valid&&out_ready: diag decrements row and col; up decrements row; left decrements col.
  - Next state uses the updated indices: (0,0) goes to DONE; one index 0 goes to EMIT (forced, out_valid may stay high back-to-back); otherwise READ.
- DONE: done=1 for exactly one cycle, busy=0 next cycle, return to IDLE.
- Latency:
  - Accepted start to first out_valid: 3 cycles for an interior cell, 1 cycle for a forced cell.
  - Handshake to next out_valid: 3 cycles interior, 1 cycle forced.
- Symbols are never trusted to stay in range: a diag/up at row 0 or a diag/left at col 0 cannot occur, because those cells always take forced directions.
- rd_row/rd_col hold their last value when rd_en=0.
- Reset mid-operation: immediate return to IDLE with all outputs 0; the aborted walk is lost; no done pulse.

Optional Feature:
- Macro TB_PATH_LEN_EN.
- Defined: path_len clears on accepted start, increments on each out_valid&&out_ready, and holds its final value after done until the next start.
- Not defined: path_len is tied to 0 and the counter is not built.

Test Plan:
- All-diag 2x2, len_a=2, len_b=2, out_ready=1, start at cycle 0 -> out_valid at cycle 3 (2,2,001), at cycle 6 (1,1,001); done pulse at cycle 7; rd_en exactly twice.
- len_a=0, len_b=3 -> steps (0,3,100), (0,2,100), (0,1,100) on consecutive cycles; rd_en never high; then done; error=0.
- Symbols (2,2)=010 and (1,2)=001 with len 2/2 -> steps (2,2,up), (1,2,diag), (0,1,left forced), then done.
- out_ready held 0 for 5 cycles during first EMIT -> out_valid stays 1 with fields constant; no rd_en; the walk resumes 3 cycles after out_ready rises.
- Error cases -> rd_symbol=011 at (2,2): error=1, done pulse, out_valid never high. len_a=200 with LEN_A=128: error=1, no reads. Next good start clears error.
- Reset in EMIT -> all outputs 0 asynchronously. With TB_PATH_LEN_EN: the second scenario (1-row walk) gives path_len=3, and the all-diag scenario gives 2.

Source files
------------

// File: rtl/nw_traceback_if.sv
// Interface bundling the traceback engine's start/length inputs, the
// symbol-memory read port, the alignment-step stream and status outputs.
// master: the traceback engine; slave: memory model / formatter / control.
interface nw_traceback_if #(
    parameter int IDX_W = 8
);
    logic             start;
    logic [IDX_W-1:0] len_a;
    logic [IDX_W-1:0] len_b;
    logic             rd_en;
    logic [IDX_W-1:0] rd_row;
    logic [IDX_W-1:0] rd_col;
    logic [2:0]       rd_symbol;
    logic             out_valid;
    logic             out_ready;
    logic [2:0]       out_dir;
    logic [IDX_W-1:0] out_row;
    logic [IDX_W-1:0] out_col;
    logic             busy;
    logic             done;
    logic             error;
    logic [IDX_W:0]   path_len;

    modport master (
        input  start, len_a, len_b, rd_symbol, out_ready,
        output rd_en, rd_row, rd_col, out_valid, out_dir, out_row, out_col,
               busy, done, error, path_len
    );

    modport slave (
        output start, len_a, len_b, rd_symbol, out_ready,
        input  rd_en, rd_row, rd_col, out_valid, out_dir, out_row, out_col,
               busy, done, error, path_len
    );
endinterface

// File: rtl/nw_traceback.sv
// Needleman-Wunsch traceback engine: walks the direction-symbol matrix from
// (len_a, len_b) back to (0,0), one synchronous symbol read per interior cell,
// and emits one alignment step per valid/ready handshake. Cells on row 0 or
// column 0 take a forced direction without touching memory.
// Optional macro TB_PATH_LEN_EN builds the path_len step counter; without it
// path_len is tied to zero.
module nw_traceback #(
    parameter int LEN_A = 128,
    parameter int LEN_B = 128,
    parameter int IDX_W = 8
) (
    input  logic          clk,
    input  logic          rst,
    nw_traceback_if.master bus
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        CAPT = 3'd2,
        EMIT = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic [2:0] DIR_LEFT = 3'b100;
    localparam logic [2:0] DIR_UP   = 3'b010;
    localparam logic [2:0] DIR_DIAG = 3'b001;

    state_t           state;
    state_t           next_state;
    logic [IDX_W-1:0] cur_row;
    logic [IDX_W-1:0] cur_col;
    logic [2:0]       dir;
    logic             error_q;
    logic [IDX_W-1:0] rd_row_q;
    logic [IDX_W-1:0] rd_col_q;

    logic             accept;
    logic             fire;
    logic             len_bad;
    logic             sym_ok;
    logic [IDX_W-1:0] step_row;
    logic [IDX_W-1:0] step_col;

    assign accept  = (state == IDLE) && bus.start;
    assign fire    = (state == EMIT) && bus.out_ready;
    assign len_bad = (32'(bus.len_a) > 32'(LEN_A)) || (32'(bus.len_b) > 32'(LEN_B));

    // Indices of the cell the current step lands on; forced cells never
    // underflow because left is only forced with col>0 and up with row>0.
    assign step_row = (dir == DIR_LEFT) ? cur_row : cur_row - 1'b1;
    assign step_col = (dir == DIR_UP)   ? cur_col : cur_col - 1'b1;

    // Only the three legal one-hot codes are accepted from memory.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
        sym_ok = 1'b0;
        case (bus.rd_symbol)
            DIR_LEFT, DIR_UP, DIR_DIAG: sym_ok = 1'b1;
            default:                    sym_ok = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (len_bad)
                        next_state = DONE;
                    else if (bus.len_a == '0 && bus.len_b == '0)
                        next_state = DONE;
                    else if (bus.len_a != '0 && bus.len_b != '0)
                        next_state = READ;
                    else
                        next_state = EMIT;
                end
            end
            READ: next_state = CAPT;
            CAPT: next_state = sym_ok ? EMIT : DONE;
            EMIT: begin
                if (bus.out_ready) begin
                    if (step_row == '0 && step_col == '0)
                        next_state = DONE;
                    else if (step_row == '0 || step_col == '0)
                        next_state = EMIT;
                    else
                        next_state = READ;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Walk datapath: current cell, step direction, sticky error, read address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_row  <= '0;
            cur_col  <= '0;
            dir      <= '0;
            error_q  <= 1'b0;
            rd_row_q <= '0;
            rd_col_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        cur_row <= bus.len_a;
                        cur_col <= bus.len_b;
                        error_q <= len_bad;
                        dir     <= (bus.len_a == '0) ? DIR_LEFT : DIR_UP;
                    end
                end
                READ: begin
                    rd_row_q <= cur_row;
                    rd_col_q <= cur_col;
                end
                CAPT: begin
                    if (sym_ok) dir     <= bus.rd_symbol;
                    else        error_q <= 1'b1;
                end
                EMIT: begin
                    if (bus.out_ready) begin
                        cur_row <= step_row;
                        cur_col <= step_col;
                        // Only meaningful when the next cell is forced.
                        dir     <= (step_row == '0) ? DIR_LEFT : DIR_UP;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from state; all read zero in IDLE after reset.
    always_comb begin
        bus.rd_en     = (state == READ);
        bus.rd_row    = (state == READ) ? cur_row : rd_row_q;
        bus.rd_col    = (state == READ) ? cur_col : rd_col_q;
        bus.out_valid = (state == EMIT);
        bus.out_dir   = (state == EMIT) ? dir     : 3'b000;
        bus.out_row   = (state == EMIT) ? cur_row : '0;
        bus.out_col   = (state == EMIT) ? cur_col : '0;
        bus.busy      = (state != IDLE);
        bus.done      = (state == DONE);
        bus.error     = error_q;
    end

`ifdef TB_PATH_LEN_EN
    logic [IDX_W:0] path_cnt;

    // Count accepted steps; cleared on start, held after done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         path_cnt <= '0;
        else if (accept) path_cnt <= '0;
        else if (fire)   path_cnt <= path_cnt + 1'b1;
    end

    assign bus.path_len = path_cnt;
`else
    logic unused_fire;
    assign unused_fire  = accept ^ fire;
    assign bus.path_len = '0;
`endif

endmodule

// File: tb/tb_nw_traceback.sv
// Self-checking bench for nw_traceback: a symbol-memory model with one-cycle
// read latency, table-driven walks, a behavioural traceback reference for
// random matrices, and hand sequences for latency, backpressure and reset.
module tb_nw_traceback;

    localparam int IDX_W = 8;
    localparam int LEN_A = 128;
    localparam int LEN_B = 128;
    localparam logic [2:0] L = 3'b100;
    localparam logic [2:0] U = 3'b010;
    localparam logic [2:0] D = 3'b001;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    nw_traceback_if #(.IDX_W(IDX_W)) bus();

    nw_traceback #(.LEN_A(LEN_A), .LEN_B(LEN_B), .IDX_W(IDX_W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [2:0] mem [0:LEN_A][0:LEN_B];

    // Synchronous-read symbol memory.
    always @(posedge clk or posedge rst) begin
        if (rst)            bus.rd_symbol <= 3'b000;
        else if (bus.rd_en) bus.rd_symbol <= mem[bus.rd_row][bus.rd_col];
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    typedef struct packed {
        logic [7:0] row;
        logic [7:0] col;
        logic [2:0] dir;
    } step_t;

    typedef struct {
        int la;
        int lb;
        int pat;
        int steps;
        int reads;
        bit err;
    } vec_t;

    step_t got_q[$];
    int    got_cyc[$];
    step_t exp_q[$];
    int    r_reads, r_first, r_done, r_hold_bad, r_path;
    bit    r_err;

    // Patterns: 0 diag, 1 up, 2 left, 3 illegal 011, 4 random with rare faults.
    task automatic fill(input int pat);
        for (int i = 0; i <= LEN_A; i++)
            for (int j = 0; j <= LEN_B; j++) begin
                case (pat)
                    0: mem[i][j] = D;
                    1: mem[i][j] = U;
                    2: mem[i][j] = L;
                    3: mem[i][j] = 3'b011;
                    default: begin
                        if ($urandom_range(0, 99) < 2)
                            mem[i][j] = ($urandom_range(0, 1) != 0) ? 3'b011 : 3'b000;
                        else
                            mem[i][j] = 3'b001 << $urandom_range(0, 2);
                    end
                endcase
            end
    endtask

    // Reference traceback straight from the walking rules.
    task automatic model(input int la, input int lb, output int reads, output bit err);
        int r;
        int c;
        logic [2:0] d;
        exp_q.delete();
        reads = 0;
        err = 0;
        r = la;
        c = lb;
        if (la > LEN_A || lb > LEN_B) begin
            err = 1;
            return;
        end
        while (r != 0 || c != 0) begin
            if (r == 0)      d = L;
            else if (c == 0) d = U;
            else begin
                reads++;
                d = mem[r][c];
                if (!(d == L || d == U || d == D)) begin
                    err = 1;
                    break;
                end
            end
            exp_q.push_back({r[7:0], c[7:0], d});
            if (d == D || d == U) r--;
            if (d == D || d == L) c--;
        end
    endtask

    // Start one walk and record every accepted step; ready is held low for
    // the first `stall` valid cycles, then is random with ready_pct percent.
    task automatic run(input int la, input int lb, input int ready_pct, input int stall);
        step_t s;
        step_t held;
        bit    pend;
        int    stall_left;
        got_q.delete();
        got_cyc.delete();
        r_reads = 0; r_first = -1; r_done = -1; r_hold_bad = 0; r_err = 0; r_path = 0;
        pend = 0;
        held = '0;
        stall_left = stall;
        @(negedge clk);
        bus.len_a     = la[7:0];
        bus.len_b     = lb[7:0];
        bus.start     = 1'b1;
        bus.out_ready = 1'b0;
        for (int cyc = 1; cyc <= 6000; cyc++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.rd_en) r_reads++;
            if (bus.done) begin
                r_done = cyc;
                r_err  = bus.error;
                r_path = int'(bus.path_len);
                bus.out_ready = 1'b0;
                break;
            end
            if (bus.out_valid) begin
                s = {bus.out_row, bus.out_col, bus.out_dir};
                if (r_first < 0) r_first = cyc;
                if (pend && s !== held) r_hold_bad++;
                if (stall_left > 0) begin
                    bus.out_ready = 1'b0;
                    stall_left--;
                end else begin
                    bus.out_ready = ($urandom_range(0, 99) < ready_pct);
                end
                if (bus.out_ready) begin
                    got_q.push_back(s);
                    got_cyc.push_back(cyc);
                    pend = 0;
                end else begin
                    pend = 1;
                    held = s;
                end
            end else begin
                bus.out_ready = ($urandom_range(0, 99) < ready_pct);
            end
        end
        check("walk_ended", (r_done >= 0) ? 32'd1 : 32'd0, 32'd1);
    endtask

    // Compare a finished walk against exp_q and expected status.
    task automatic compare(input string tag, input int exp_reads, input bit exp_err);
        int n;
        check({tag, "_steps"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            if (got_q[i] !== exp_q[i])
                check($sformatf("%s_step%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        check({tag, "_reads"}, r_reads, exp_reads);
        check({tag, "_err"}, 32'(r_err), 32'(exp_err));
        check({tag, "_hold"}, r_hold_bad, 0);
`ifdef TB_PATH_LEN_EN
        check({tag, "_path_len"}, r_path, exp_q.size());
`else
        check({tag, "_path_len"}, r_path, 0);
`endif
        @(negedge clk);
        check({tag, "_idle"}, {bus.busy, bus.done, bus.error}, {2'b00, exp_err});
    endtask

    vec_t vecs[14];
    int   m_reads;
    bit   m_err;

    initial begin
        vecs[0]  = '{2,   2,   0, 2,   2,   0};
        vecs[1]  = '{0,   3,   0, 3,   0,   0};
        vecs[2]  = '{3,   0,   0, 3,   0,   0};
        vecs[3]  = '{0,   0,   0, 0,   0,   0};
        vecs[4]  = '{3,   2,   1, 5,   3,   0};
        vecs[5]  = '{2,   3,   2, 5,   3,   0};
        vecs[6]  = '{2,   2,   3, 0,   1,   1};
        vecs[7]  = '{1,   1,   0, 1,   1,   0};
        vecs[8]  = '{200, 2,   0, 0,   0,   1};
        vecs[9]  = '{2,   129, 0, 0,   0,   1};
        vecs[10] = '{128, 128, 0, 128, 128, 0};
        vecs[11] = '{128, 0,   0, 128, 0,   0};
        vecs[12] = '{1,   3,   0, 3,   1,   0};
        vecs[13] = '{5,   3,   1, 8,   5,   0};

        rst = 1'b1;
        bus.start = 1'b0;
        bus.len_a = '0;
        bus.len_b = '0;
        bus.out_ready = 1'b0;
        fill(0);
        #12;
        check("reset_outputs",
              {bus.rd_en, bus.rd_row, bus.rd_col, bus.out_valid, bus.out_dir, bus.out_row,
               bus.out_col, bus.busy, bus.done, bus.error, bus.path_len}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // All-diag 2x2 with exact cycle timing.
        fill(0);
        run(2, 2, 100, 0);
        model(2, 2, m_reads, m_err);
        compare("diag2x2", 2, 0);
        check("diag2x2_first_valid", r_first, 3);
        if (got_cyc.size() >= 2) check("diag2x2_second_valid", got_cyc[1], 6);
        check("diag2x2_done_cycle", r_done, 7);

        // Mixed symbols ending in a forced left step.
        mem[2][2] = U;
        mem[1][2] = D;
        run(2, 2, 100, 0);
        exp_q.delete();
        exp_q.push_back({8'd2, 8'd2, U});
        exp_q.push_back({8'd1, 8'd2, D});
        exp_q.push_back({8'd0, 8'd1, L});
        compare("mixed", 2, 0);

        // Backpressure: ready low for 5 cycles on the first step.
        fill(0);
        run(2, 2, 100, 5);
        model(2, 2, m_reads, m_err);
        compare("stall", 2, 0);
        if (got_cyc.size() >= 2) begin
            check("stall_accept_cycle", got_cyc[0], 8);
            check("stall_next_valid", got_cyc[1], 11);
        end

        // Table-driven walks.
        for (int i = 0; i < 14; i++) begin
            fill(vecs[i].pat);
            run(vecs[i].la, vecs[i].lb, 100, 0);
            model(vecs[i].la, vecs[i].lb, m_reads, m_err);
            check($sformatf("v%0d_tbl_steps", i), got_q.size(), vecs[i].steps);
            compare($sformatf("v%0d", i), vecs[i].reads, vecs[i].err);
        end

        // Randomised matrices against the reference model.
        for (int t = 0; t < 25; t++) begin
            int la;
            int lb;
            la = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 10));
            lb = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 10));
            fill(4);
            model(la, lb, m_reads, m_err);
            run(la, lb, 70, int'($urandom_range(0, 2)));
            compare($sformatf("rnd%0d", t), m_reads, m_err);
        end

        // Asynchronous reset while a step is waiting in EMIT.
        @(negedge clk);
        bus.len_a = 8'd0;
        bus.len_b = 8'd3;
        bus.start = 1'b1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        check("rst_pre_valid", {bus.out_valid, bus.out_row, bus.out_col, bus.out_dir},
              {1'b1, 8'd0, 8'd3, L});
        #2 rst = 1'b1;
        #1;
        check("rst_mid_outputs",
              {bus.rd_en, bus.rd_row, bus.rd_col, bus.out_valid, bus.out_dir, bus.out_row,
               bus.out_col, bus.busy, bus.done, bus.error, bus.path_len}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        begin
            int seen;
            seen = 0;
            for (int k = 0; k < 6; k++) begin
                @(negedge clk);
                if (bus.done || bus.busy || bus.out_valid) seen++;
            end
            check("rst_walk_lost", seen, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
